// File: rtl/sram_xbar_n.sv
// One-master to N-slave crossbar for the fixed-latency SRAM data port.
// Requests are address-decoded against per-slave base/mask windows; read data is routed back by a tag pipeline.
module sram_xbar_n #(
   parameter int unsigned LEN_ADDR     = 64,
   parameter int unsigned LEN_DATA     = 64,
   parameter int unsigned NUM_SLAVES   = 4,
   parameter logic [NUM_SLAVES*LEN_ADDR-1:0] SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES*LEN_ADDR-1:0] SLAVE_MASK = '0,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [LEN_DATA-1:0] DEFAULT_RDATA = '0,
   parameter int unsigned ERR_CNT_W    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [LEN_ADDR-1:0]              master_addra,
   input  logic [LEN_DATA-1:0]              master_dina,
   output logic [LEN_DATA-1:0]              master_douta,
   input  logic                             master_ena,
   input  logic [LEN_DATA/8-1:0]            master_wea,
   output logic                             master_err,
   output logic [NUM_SLAVES*LEN_ADDR-1:0]   slave_addra,
   output logic [NUM_SLAVES*LEN_DATA-1:0]   slave_dina,
   input  logic [NUM_SLAVES*LEN_DATA-1:0]   slave_douta,
   output logic [NUM_SLAVES-1:0]            slave_ena,
   output logic [NUM_SLAVES*LEN_DATA/8-1:0] slave_wea,
   output logic [ERR_CNT_W-1:0]             err_count,
   output logic [LEN_ADDR-1:0]              err_addr
);

   localparam int unsigned LEN_BE = LEN_DATA / 8;
   localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   logic [SEL_W-1:0]        w_sel;
   logic                    w_miss;
   logic [READ_LATENCY-1:0] r_tag_valid;
   logic [READ_LATENCY-1:0] r_tag_miss;
   logic [SEL_W-1:0]        r_tag_sel [READ_LATENCY];
   logic [SEL_W-1:0]        r_ret_sel;
   logic                    r_ret_miss;
   logic                    r_err;
   logic                    w_pre_err;
   logic                    w_last_valid;
   logic [SEL_W-1:0]        w_route_sel;
   logic                    w_route_miss;
   logic [LEN_DATA-1:0]     w_slave_rd;
   logic [ERR_CNT_W-1:0]    r_err_count;
   logic [LEN_ADDR-1:0]     r_err_addr;

   // Address decode: scanning downwards lets the lowest matching index win.
   always_comb begin
      w_miss = 1'b1;
      w_sel  = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((master_addra & SLAVE_MASK[i*LEN_ADDR +: LEN_ADDR]) == SLAVE_BASE[i*LEN_ADDR +: LEN_ADDR]) begin
            w_miss = 1'b0;
            w_sel  = SEL_W'(i);
         end
      end
   end

   // Zero-latency request forwarding; unmapped requests reach no slave.
   always_comb begin
      slave_ena = '0;
      slave_wea = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!rst && !w_miss && (w_sel == SEL_W'(i))) begin
            slave_ena[i]                 = master_ena;
            slave_wea[i*LEN_BE +: LEN_BE] = master_wea;
         end
      end
   end

   assign slave_addra = {NUM_SLAVES{master_addra}};
   assign slave_dina  = {NUM_SLAVES{master_dina}};

   // Response tags; writes travel too so error timing is the same for all requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_valid <= '0;
         r_tag_miss  <= '0;
         for (int i = 0; i < READ_LATENCY; i++) r_tag_sel[i] <= '0;
      end else begin
         r_tag_valid[0] <= master_ena;
         r_tag_miss[0]  <= w_miss;
         r_tag_sel[0]   <= w_sel;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_tag_valid[i] <= r_tag_valid[i-1];
            r_tag_miss[i]  <= r_tag_miss[i-1];
            r_tag_sel[i]   <= r_tag_sel[i-1];
         end
      end
   end

   // The error flop is fed from the stage feeding the last one so it lines up with the response.
   generate
      if (READ_LATENCY == 1) begin : g_pre_in
         assign w_pre_err = master_ena & w_miss;
      end else begin : g_pre_tag
         assign w_pre_err = r_tag_valid[READ_LATENCY-2] & r_tag_miss[READ_LATENCY-2];
      end
   endgenerate

   assign w_last_valid = r_tag_valid[READ_LATENCY-1];
   assign w_route_sel  = w_last_valid ? r_tag_sel[READ_LATENCY-1]  : r_ret_sel;
   assign w_route_miss = w_last_valid ? r_tag_miss[READ_LATENCY-1] : r_ret_miss;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ret_sel  <= '0;
         r_ret_miss <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_pre_err;
         if (w_last_valid) begin
            r_ret_sel  <= r_tag_sel[READ_LATENCY-1];
            r_ret_miss <= r_tag_miss[READ_LATENCY-1];
         end
      end
   end

   always_comb begin
      w_slave_rd = slave_douta[0 +: LEN_DATA];
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (w_route_sel == SEL_W'(i)) w_slave_rd = slave_douta[i*LEN_DATA +: LEN_DATA];
      end
   end

   assign master_douta = w_route_miss ? DEFAULT_RDATA : w_slave_rd;
   assign master_err   = r_err & ~rst;

   // Unmapped-access log, updated at request time.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
      end else if (master_ena && w_miss) begin
         if (r_err_count != {ERR_CNT_W{1'b1}}) r_err_count <= r_err_count + ERR_CNT_W'(1);
         r_err_addr <= master_addra;
      end
   end

   assign err_count = r_err_count;
   assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_sram_xbar_n.sv
// Bench for sram_xbar_n: two configurations (latency 1 / 4-bit counter, latency 3 / overlapping windows)
// driven by shared master stimulus and checked against a request-level response model.
module tb_sram_xbar_n;

   localparam logic [63:0] DEF = 64'hDEAD_BEEF_0BAD_F00D;
   localparam logic [127:0] BASE_A = {64'h6000_0000, 64'h0};
   localparam logic [127:0] MASK_A = {~64'h7, 64'hFFFF_FFFF_FFFF_F000};
   localparam logic [191:0] BASE_B = {64'h0, 64'h6000_0000, 64'h0};
   localparam logic [191:0] MASK_B = {64'hFFFF_FFFF_FFFF_0000, ~64'h7, 64'hFFFF_FFFF_FFFF_F000};

   typedef struct {
      int          due;
      logic [63:0] data;
      logic        miss;
   } resp_t;

   logic         clk;
   logic         rst;
   logic [63:0]  m_addr;
   logic [63:0]  m_dina;
   logic         m_ena;
   logic [7:0]   m_wea;

   logic [63:0]  a_mdout, b_mdout;
   logic         a_merr, b_merr;
   logic [127:0] a_saddr, a_sdina, a_sdout;
   logic [191:0] b_saddr, b_sdina, b_sdout;
   logic [1:0]   a_sena;
   logic [2:0]   b_sena;
   logic [15:0]  a_swea;
   logic [23:0]  b_swea;
   logic [3:0]   a_cnt;
   logic [15:0]  b_cnt;
   logic [63:0]  a_eaddr, b_eaddr;

   logic [63:0]  a_mem [2][8];
   logic [63:0]  a_dout [2];
   logic [63:0]  b_mem [3][8];
   logic [63:0]  b_dout [3];
   logic         b_pv [3][2];
   logic [63:0]  b_pd [3][2];

   logic [63:0]  ra_mem [2][8];
   logic [63:0]  rb_mem [3][8];
   resp_t        qa [$];
   resp_t        qb [$];
   logic [63:0]  ha, hb;
   logic [3:0]   ca;
   logic [15:0]  cb;
   logic [63:0]  ea, eb;
   int           cyc;
   int           nassert;
   int           nfail;

   sram_xbar_n #(
      .LEN_ADDR(64), .LEN_DATA(64), .NUM_SLAVES(2),
      .SLAVE_BASE(BASE_A), .SLAVE_MASK(MASK_A),
      .READ_LATENCY(1), .DEFAULT_RDATA(DEF), .ERR_CNT_W(4)
   ) dut_a (
      .clk(clk), .rst(rst),
      .master_addra(m_addr), .master_dina(m_dina), .master_douta(a_mdout),
      .master_ena(m_ena), .master_wea(m_wea), .master_err(a_merr),
      .slave_addra(a_saddr), .slave_dina(a_sdina), .slave_douta(a_sdout),
      .slave_ena(a_sena), .slave_wea(a_swea),
      .err_count(a_cnt), .err_addr(a_eaddr)
   );

   sram_xbar_n #(
      .LEN_ADDR(64), .LEN_DATA(64), .NUM_SLAVES(3),
      .SLAVE_BASE(BASE_B), .SLAVE_MASK(MASK_B),
      .READ_LATENCY(3), .DEFAULT_RDATA(DEF), .ERR_CNT_W(16)
   ) dut_b (
      .clk(clk), .rst(rst),
      .master_addra(m_addr), .master_dina(m_dina), .master_douta(b_mdout),
      .master_ena(m_ena), .master_wea(m_wea), .master_err(b_merr),
      .slave_addra(b_saddr), .slave_dina(b_sdina), .slave_douta(b_sdout),
      .slave_ena(b_sena), .slave_wea(b_swea),
      .err_count(b_cnt), .err_addr(b_eaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pat(int d, int s, int w);
      return {8'(d), 8'(s), 8'(w), 40'hC0_FFEE_1234};
   endfunction

   assign a_sdout = {a_dout[1], a_dout[0]};
   assign b_sdout = {b_dout[2], b_dout[1], b_dout[0]};

   // SRAM slaves: an enabled access returns the pre-write word after the latency, douta holds otherwise.
   always @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            a_dout[s] <= '0;
            for (int w = 0; w < 8; w++) a_mem[s][w] <= pat(0, s, w);
         end
         for (int s = 0; s < 3; s++) begin
            b_dout[s]  <= '0;
            b_pv[s][0] <= 1'b0;
            b_pv[s][1] <= 1'b0;
            for (int w = 0; w < 8; w++) b_mem[s][w] <= pat(1, s, w);
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (a_sena[s]) begin
               a_dout[s] <= a_mem[s][a_saddr[s*64+3 +: 3]];
               for (int b = 0; b < 8; b++)
                  if (a_swea[s*8+b]) a_mem[s][a_saddr[s*64+3 +: 3]][8*b +: 8] <= a_sdina[s*64+8*b +: 8];
            end
         end
         for (int s = 0; s < 3; s++) begin
            b_pv[s][0] <= b_sena[s];
            b_pd[s][0] <= b_mem[s][b_saddr[s*64+3 +: 3]];
            b_pv[s][1] <= b_pv[s][0];
            b_pd[s][1] <= b_pd[s][0];
            if (b_pv[s][1]) b_dout[s] <= b_pd[s][1];
            if (b_sena[s])
               for (int b = 0; b < 8; b++)
                  if (b_swea[s*8+b]) b_mem[s][b_saddr[s*64+3 +: 3]][8*b +: 8] <= b_sdina[s*64+8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] gen_addr(int cat);
      case (cat)
         0:       return 64'($urandom_range(0, 511)) << 3;
         1:       return 64'h6000_0000 + 64'($urandom_range(0, 7));
         2:       return 64'h1000 + (64'($urandom_range(0, 16'h1DFF)) << 3);
         default: return {1'b1, 31'($urandom), 32'($urandom)};
      endcase
   endfunction

   // cat: 0 = low window of slave 0, 1 = slave 1, 2 = 0x1000..0xFFFF (slave 2 of B only), 3 = unmapped.
   task automatic step(input logic en, input logic [63:0] ad, input logic [7:0] we,
                       input logic [63:0] di, input logic rs, input int cat);
      resp_t       e;
      int          sel_a, sel_b;
      logic        miss_a, miss_b;
      logic        xerr;
      logic [1:0]  xena_a;
      logic [2:0]  xena_b;
      logic [15:0] xwea_a;
      logic [23:0] xwea_b;
      logic [63:0] d;
      logic [2:0]  idx;

      @(posedge clk);
      cyc++;
      #1;
      rst    = rs;
      m_ena  = en;
      m_addr = ad;
      m_wea  = we;
      m_dina = di;
      sel_a  = cat;
      miss_a = (cat >= 2);
      sel_b  = cat;
      miss_b = (cat == 3);
      #1;

      xerr = 1'b0;
      if (qa.size() != 0 && qa[0].due == cyc) begin
         e = qa.pop_front(); ha = e.data; xerr = e.miss && !rs;
      end
      chk("a_douta", a_mdout, ha);
      chk("a_err", a_merr, xerr);
      xerr = 1'b0;
      if (qb.size() != 0 && qb[0].due == cyc) begin
         e = qb.pop_front(); hb = e.data; xerr = e.miss && !rs;
      end
      chk("b_douta", b_mdout, hb);
      chk("b_err", b_merr, xerr);
      chk("a_err_count", a_cnt, ca);
      chk("b_err_count", b_cnt, cb);
      chk("a_err_addr", a_eaddr, ea);
      chk("b_err_addr", b_eaddr, eb);

      xena_a = (en && !rs && !miss_a) ? 2'(1 << sel_a) : 2'b0;
      xena_b = (en && !rs && !miss_b) ? 3'(1 << sel_b) : 3'b0;
      for (int s = 0; s < 2; s++) xwea_a[s*8 +: 8] = (!rs && !miss_a && sel_a == s) ? we : 8'h0;
      for (int s = 0; s < 3; s++) xwea_b[s*8 +: 8] = (!rs && !miss_b && sel_b == s) ? we : 8'h0;
      chk("a_slave_ena", a_sena, xena_a);
      chk("b_slave_ena", b_sena, xena_b);
      chk("a_slave_wea", a_swea, xwea_a);
      chk("b_slave_wea", b_swea, xwea_b);
      chk("a_addra_bcast", a_saddr, {2{ad}});
      chk("b_dina_bcast", b_sdina, {3{di}});

      idx = ad[5:3];
      if (rs) begin
         qa.delete(); qb.delete();
         ha = '0; hb = '0; ca = '0; cb = '0; ea = '0; eb = '0;
         for (int s = 0; s < 2; s++) for (int w = 0; w < 8; w++) ra_mem[s][w] = pat(0, s, w);
         for (int s = 0; s < 3; s++) for (int w = 0; w < 8; w++) rb_mem[s][w] = pat(1, s, w);
      end else if (en) begin
         if (miss_a) begin
            d = DEF;
            if (ca != 4'hF) ca = ca + 4'd1;
            ea = ad;
         end else begin
            d = ra_mem[sel_a][idx];
            for (int b = 0; b < 8; b++) if (we[b]) ra_mem[sel_a][idx][8*b +: 8] = di[8*b +: 8];
         end
         qa.push_back('{due: cyc + 1, data: d, miss: miss_a});
         if (miss_b) begin
            d = DEF;
            cb = cb + 16'd1;
            eb = ad;
         end else begin
            d = rb_mem[sel_b][idx];
            for (int b = 0; b < 8; b++) if (we[b]) rb_mem[sel_b][idx][8*b +: 8] = di[8*b +: 8];
         end
         qb.push_back('{due: cyc + 3, data: d, miss: miss_b});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 64'h0, 8'h0, 64'h0, 1'b0, 0);
   endtask

   initial begin
      int          cat;
      logic        en;
      logic [7:0]  we;
      nassert = 0;
      nfail   = 0;
      cyc     = 0;
      rst     = 1'b1;
      m_ena   = 1'b0;
      m_addr  = '0;
      m_wea   = '0;
      m_dina  = '0;

      for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 8'h0, 64'h0, 1'b1, 0);
      idle(2);

      step(1'b1, 64'h10, 8'h00, 64'h0, 1'b0, 0);
      step(1'b1, 64'h6000_0000, 8'h01, 64'h41, 1'b0, 1);
      step(1'b1, 64'h6000_0000, 8'h00, 64'h0, 1'b0, 1);
      idle(3);
      step(1'b1, 64'h8000_0000, 8'h00, 64'h0, 1'b0, 3);
      idle(3);

      step(1'b1, 64'h2000, 8'h00, 64'h0, 1'b0, 2);
      step(1'b1, 64'h2008, 8'hF0, 64'h1122_3344_5566_7788, 1'b0, 2);
      step(1'b1, 64'h2008, 8'h00, 64'h0, 1'b0, 2);
      idle(4);

      step(1'b1, 64'h18, 8'h00, 64'h0, 1'b0, 0);
      step(1'b1, 64'h6000_0004, 8'h00, 64'h0, 1'b0, 1);
      step(1'b1, 64'h20, 8'h00, 64'h0, 1'b0, 0);
      idle(5);

      step(1'b1, 64'h8000_0040, 8'h00, 64'h0, 1'b0, 3);
      step(1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 0);
      step(1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 0);
      idle(4);

      for (int i = 0; i < 17; i++) step(1'b1, 64'h8000_0000 + 64'(i * 8), 8'h00, 64'h0, 1'b0, 3);
      idle(4);

      for (int i = 0; i < 400; i++) begin
         cat = int'($urandom_range(0, 3));
         en  = ($urandom_range(0, 3) != 0);
         we  = (en && $urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
         step(en, gen_addr(cat), we, {$urandom, $urandom}, ($urandom_range(0, 63) == 0), cat);
      end
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule

// File: doc/sram_xbar_n.md
Name: sram_xbar_n

Overview:
- Parametrised 1-master to N-slave crossbar for the SRAM-style data port (addra/dina/douta/ena/wea, fixed read latency).
- Sits between the pipeline data port and the data SRAM, UART and future MMIO slaves.
- Decodes each request against per-slave base/mask windows and forwards it to exactly one slave.
- Routes read data back after a configurable latency, and flags and logs accesses to unmapped addresses.

Parameters:
- LEN_ADDR, 64, address width.
- LEN_DATA, 64, data width; must be a multiple of 8.
- NUM_SLAVES, 4, number of slave ports (1..8).
- SLAVE_BASE, 0, packed NUM_SLAVES*LEN_ADDR vector; slice i is the base address of slave i.
- SLAVE_MASK, 0, packed NUM_SLAVES*LEN_ADDR vector; slice i is the compare mask of slave i.
- READ_LATENCY, 1, cycles from request to valid slave douta (1..4); identical for all slaves.
- DEFAULT_RDATA, 0, LEN_DATA value returned for unmapped reads.
- ERR_CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- master_addra  in  LEN_ADDR  request address.
- master_dina  in  LEN_DATA  write data.
- master_douta  out  LEN_DATA  read data.
- master_ena  in  1  request valid, one request per cycle.
- master_wea  in  LEN_DATA/8  byte write enables; all zero means read.
- master_err  out  1  unmapped-access pulse, aligned with the response.
- slave_addra  out  NUM_SLAVES*LEN_ADDR  per-slave address.
- slave_dina  out  NUM_SLAVES*LEN_DATA  per-slave write data.
- slave_douta  in  NUM_SLAVES*LEN_DATA  per-slave read data.
- slave_ena  out  NUM_SLAVES  per-slave enable.
- slave_wea  out  NUM_SLAVES*LEN_DATA/8  per-slave byte enables.
- err_count  out  ERR_CNT_W  saturating count of unmapped accesses.
- err_addr  out  LEN_ADDR  address of the most recent unmapped access.

Behaviour:
- Decode (combinational):
  - hit_i = ((master_addra & MASK_i) == BASE_i).
  - On overlapping windows the lowest index wins.
  - sel is the winning index; miss = no hit.
- Request forwarding (combinational, zero latency):
  - addra and dina are broadcast to every slave.
  - slave_ena[i] = master_ena & !rst & win_i.
  - slave_wea slice i = master_wea when win_i, else 0.
  - On a miss no slave is enabled and the write is dropped.
- Response tag pipeline, READ_LATENCY stages:
  - Each entry holds {valid, sel, miss}.
  - Stage 0 loads {master_ena, sel, miss} every cycle; later stages shift.
  - Writes occupy tags as well, so master_err timing is uniform.
- Output routing:
  - When the last stage is valid: master_douta = miss ? DEFAULT_RDATA : slave_douta[sel].
  - On that update, a holding register ret_sel/ret_miss is loaded.
  - When the last stage is not valid, master_douta keeps routing from ret_sel/ret_miss. Slaves hold douta while idle, so the master sees held data.
- master_err is registered and equals (last-stage valid & miss), one cycle wide per unmapped access. Back-to-back misses give a continuous high.
- err_count increments on each miss at request time (master_ena & miss) and saturates at all-ones.
- err_addr loads master_addra on the same event and is otherwise held.
- Reset (synchronous, rst high at a clk edge):
  - All tag entries invalid; ret_sel=0, ret_miss=0, so master_douta routes slave_douta[0].
  - master_err=0, err_count=0, err_addr=0.
  - slave_ena and slave_wea are forced to 0 while rst is high.
  - In-flight responses are discarded; no master_err fires for requests issued before reset.
- Simultaneous miss request and completing miss response: the count increments once, for the request.
- NUM_SLAVES=1 degenerates to a pass-through with miss detection.

Test Plan:
- Map: NUM_SLAVES=2, S0 base 0x0 mask 0xFFFF_F000, S1 base 0x6000_0000 mask ~0x7, READ_LATENCY=1.
  - Read 0x10 -> slave_ena=2'b01 same cycle; next cycle master_douta = slave0 data, master_err=0.
- Write 0x6000_0000 with wea=8'h01, dina=0x41 -> slave_ena=2'b10, slave1 wea=8'h01, slave0 wea=0; master_err stays 0.
- Read unmapped 0x8000_0000 -> no slave_ena; next cycle master_douta=DEFAULT_RDATA, master_err=1 for one cycle, err_count=1, err_addr=0x8000_0000.
- READ_LATENCY=3, back-to-back reads S0, S1, S0 -> douta sequence matches slave0, slave1, slave0 on cycles 3, 4, 5; master_douta holds the slave0 route afterwards.
- Issue an unmapped read, then assert rst on the next cycle -> master_err never asserts, err_count=0, slave_ena=0 while rst is high.
- Force err_count to all-ones with ERR_CNT_W=4 (15 misses) plus 2 more -> err_count stays 4'hF, err_addr = last miss address.
